// File: rtl/noc_node_pkg.sv
// noc_node_pkg: shared definitions for the NoC node endpoint.
//   PKT_W_DEF / FLIT_W_DEF : default packet and flit widths
//   tx_state_t             : outbound serialiser states
//   nflits()               : number of flits per packet
package noc_node_pkg;

    localparam int PKT_W_DEF  = 32;
    localparam int FLIT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

    function automatic int nflits(input int pkt_w, input int flit_w);
        return pkt_w / flit_w;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: show-ahead synchronous queue with occupancy count.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push/push_data : enqueue request (ignored while full)
//   pop          : dequeue request (ignored while empty)
//   head         : entry at the front, valid while !empty
//   count/full/empty : occupancy status
module noc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push while full is dropped even if a pop happens in the same cycle;
    // a pop while empty is ignored even if a push happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Explicit wrap compare so non-power-of-2 depths work.
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/noc_node_port.sv
// noc_node_port: NoC node endpoint.
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   pkt_in/pkt_in_avail  : packet write into the TX queue (dropped while cQ_full)
//   cQ_full, tx_count    : TX queue status
//   pkt_out/pkt_out_avail/pkt_out_ready : RX queue head, show-ahead, pop handshake
//   rx_count             : RX queue occupancy
//   free_outbound        : router can take a packet (sampled only when idle)
//   put_outbound/payload_outbound : outbound flits, MSB-first
//   free_inbound         : room for a new inbound packet
//   put_inbound/payload_inbound   : inbound flits, gaps allowed
//   rx_err               : sticky flag, a packet started while free_inbound=0
module noc_node_port
    import noc_node_pkg::*;
#(
    parameter int NODEID    = 0,
    parameter int PKT_W     = PKT_W_DEF,
    parameter int FLIT_W    = FLIT_W_DEF,
    parameter int TXQ_DEPTH = 4,
    parameter int RXQ_DEPTH = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [PKT_W-1:0]                 pkt_in,
    input  logic                             pkt_in_avail,
    output logic                             cQ_full,
    output logic [$clog2(TXQ_DEPTH+1)-1:0]   tx_count,
    output logic [PKT_W-1:0]                 pkt_out,
    output logic                             pkt_out_avail,
    input  logic                             pkt_out_ready,
    output logic [$clog2(RXQ_DEPTH+1)-1:0]   rx_count,
    input  logic                             free_outbound,
    output logic                             put_outbound,
    output logic [FLIT_W-1:0]                payload_outbound,
    output logic                             free_inbound,
    input  logic                             put_inbound,
    input  logic [FLIT_W-1:0]                payload_inbound,
    output logic                             rx_err
);

    localparam int NFLITS = nflits(PKT_W, FLIT_W);
    localparam int SH_W   = PKT_W - FLIT_W;      // flits still to send / already assembled
    localparam int TC_W   = $clog2(NFLITS + 1);
    localparam int RC_W   = $clog2(NFLITS);

    // Elaboration-time parameter sanity checks.
    if ((PKT_W % FLIT_W) != 0 || NFLITS < 2) begin : g_bad_geometry
        $error("noc_node_port: PKT_W must be a multiple of FLIT_W with at least 2 flits");
    end
    if (TXQ_DEPTH < 1 || RXQ_DEPTH < 1 || NODEID < 0) begin : g_bad_sizes
        $error("noc_node_port: queue depths must be >= 1 and NODEID non-negative");
    end

    // ---------------- TX queue and serialiser ----------------
    tx_state_t         state_q, state_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [TC_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic              put_q, put_d;
    logic [FLIT_W-1:0] payload_q, payload_d;
    logic              tx_pop;
    logic              tx_empty;
    logic [PKT_W-1:0]  tx_head;

    noc_sync_fifo #(.WIDTH(PKT_W), .DEPTH(TXQ_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (pkt_in_avail),
        .push_data (pkt_in),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .full      (cQ_full),
        .empty     (tx_empty)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        tx_cnt_d  = tx_cnt_q;
        put_d     = 1'b0;
        payload_d = payload_q;     // payload holds while put_outbound is low
        tx_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_empty && free_outbound) begin
                    tx_pop    = 1'b1;
                    payload_d = tx_head[PKT_W-1 -: FLIT_W];
                    shift_d   = tx_head[SH_W-1:0];
                    put_d     = 1'b1;
                    tx_cnt_d  = TC_W'(1);
                    state_d   = SEND;
                end
            end
            SEND: begin
                payload_d = shift_q[SH_W-1 -: FLIT_W];
                shift_d   = SH_W'({shift_q, {FLIT_W{1'b0}}});
                put_d     = 1'b1;
                // tx_cnt_q counts flits already sent; this edge sends the next one.
                if (tx_cnt_q == TC_W'(NFLITS - 1)) begin
                    state_d = GAP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            tx_cnt_q  <= '0;
            put_q     <= 1'b0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            tx_cnt_q  <= tx_cnt_d;
            put_q     <= put_d;
            payload_q <= payload_d;
        end
    end

    assign put_outbound     = put_q;
    assign payload_outbound = payload_q;

    // ---------------- RX assembler and queue ----------------
    logic [RC_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [SH_W-1:0]  asm_q, asm_d;
    logic             err_q, err_d;
    logic             rx_push;
    logic             rx_empty;
    logic             rx_full;
    logic             rx_busy;
    logic [PKT_W-1:0] rx_head;
    logic [31:0]      rx_occ;

    noc_sync_fifo #(.WIDTH(PKT_W), .DEPTH(RXQ_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data ({asm_q, payload_inbound}),
        .pop       (pkt_out_ready),
        .head      (rx_head),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // A packet in assembly reserves a queue slot, so a completed packet
    // always finds room.
    assign rx_busy      = (rx_cnt_q != '0);
    assign rx_occ       = 32'(rx_count) + 32'(rx_busy);
    assign free_inbound = (rx_occ < 32'(RXQ_DEPTH));

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        asm_d    = asm_q;
        err_d    = err_q;
        rx_push  = 1'b0;
        if (put_inbound) begin
            if (!rx_busy && !free_inbound) begin
                err_d = 1'b1;          // new packet with no room: drop the flit
            end else if (rx_cnt_q == RC_W'(NFLITS - 1)) begin
                rx_push  = 1'b1;
                rx_cnt_d = '0;
                // Defensive: a completed packet meeting a full queue would be lost.
                if (rx_full) begin
                    err_d = 1'b1;
                end
            end else begin
                asm_d    = SH_W'({asm_q, payload_inbound});
                rx_cnt_d = rx_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_cnt_q <= '0;
            asm_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rx_cnt_q <= rx_cnt_d;
            asm_q    <= asm_d;
            err_q    <= err_d;
        end
    end

    assign pkt_out_avail = !rx_empty;
    assign pkt_out       = rx_empty ? '0 : rx_head;
    assign rx_err        = err_q;

endmodule

// File: doc/noc_node_port.md
Name: noc_node_port

Overview:
- Parametrised successor to the current NoC node endpoint.
- Accepts whole packets from the testbench into a TX queue and serialises them MSB-first into FLIT_W-bit flits toward the router.
- Deserialises inbound flits, tolerating gaps between them, into an RX queue with ready/valid backpressure to the testbench.
- Adds queue-occupancy outputs and an inbound protocol-violation flag.

Parameters:
- NODEID, 0, node identifier (informational; no header rewriting).
- PKT_W, 32, packet width in bits.
- FLIT_W, 8, flit width in bits. PKT_W % FLIT_W == 0 is required. NFLITS = PKT_W/FLIT_W, and NFLITS >= 2.
- TXQ_DEPTH, 4, TX queue entries (>= 1, any integer).
- RXQ_DEPTH, 2, RX queue entries (>= 1, any integer).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pkt_in  in  PKT_W  packet from testbench.
- pkt_in_avail  in  1  write strobe for pkt_in.
- cQ_full  out  1  TX queue full.
- tx_count  out  $clog2(TXQ_DEPTH+1)  TX queue occupancy.
- pkt_out  out  PKT_W  head of RX queue.
- pkt_out_avail  out  1  RX queue non-empty.
- pkt_out_ready  in  1  testbench pops RX head.
- rx_count  out  $clog2(RXQ_DEPTH+1)  RX queue occupancy.
- free_outbound  in  1  router can accept a packet.
- put_outbound  out  1  flit valid toward router.
- payload_outbound  out  FLIT_W  flit toward router.
- free_inbound  out  1  node can accept a packet.
- put_inbound  in  1  flit valid from router.
- payload_inbound  in  FLIT_W  flit from router.
- rx_err  out  1  sticky inbound protocol violation.

Behaviour:
- Reset (asynchronous, immediate): all queues empty. cQ_full=0, tx_count=0, rx_count=0, pkt_out_avail=0, pkt_out=0, put_outbound=0, payload_outbound=0, free_inbound=1, rx_err=0. TX FSM goes to IDLE; any partial inbound packet is discarded. Reset mid-packet truncates the outbound packet, and put_outbound drops asynchronously.
- TX queue:
  - Write on pkt_in_avail && !cQ_full. A write while full is silently dropped.
  - cQ_full = (tx_count == TXQ_DEPTH).
  - Simultaneous write and pop while full: pop occurs, write dropped.
  - Simultaneous write and pop while empty: write only (no pop).
- TX FSM states:
  - IDLE: at an edge where the TX queue is non-empty and free_outbound=1, pop the head into the shift register, register flit 0 (bits PKT_W-1 -: FLIT_W), set put_outbound=1, then go to SEND.
  - SEND: each edge registers the next flit with put_outbound=1. After flit NFLITS-1, go to GAP.
  - GAP: put_outbound=0 for exactly one cycle, then IDLE.
  - Flits of one packet are contiguous; free_outbound is ignored outside IDLE.
  - Latency: packet written at edge N reaches the router as header flit valid after edge N+1 at the earliest.
  - Back-to-back packets are separated by exactly 1 idle cycle.
  - payload_outbound holds its last value while put_outbound=0.
- RX assembly:
  - Each edge with put_inbound=1 shifts payload_inbound into the LSBs of the assembly register and increments the flit counter.
  - Cycles with put_inbound=0 mid-packet simply wait; there is no timeout.
  - On the NFLITS-th flit, {assembly[PKT_W-FLIT_W-1:0], payload_inbound} is pushed into the RX queue at that same edge, and the counter clears.
  - pkt_out_avail rises in the following cycle.
- free_inbound = (rx_count + (flit counter != 0)) < RXQ_DEPTH. It is combinational from flops only.
- A put_inbound with flit counter == 0 while free_inbound=0 is a violation: the flit is dropped and rx_err is set (sticky until reset).
- RX queue:
  - Show-ahead: pkt_out = head whenever pkt_out_avail=1; pkt_out = 0 when empty.
  - Pop on pkt_out_avail && pkt_out_ready.
  - Push and pop in the same cycle is permitted; rx_count is unchanged.
- Counters and pointers wrap modulo DEPTH, so non-power-of-2 depths use explicit wrap compares.

Decomposition:
- Package noc_node_pkg holds:
  - default localparams (PKT_W_DEF=32, FLIT_W_DEF=8);
  - tx_state_t enum {IDLE, SEND, GAP};
  - a function nflits(pkt_w, flit_w).
- Sub-module noc_sync_fifo #(WIDTH, DEPTH):
  - show-ahead queue with count/full/empty, asynchronous active-high reset;
  - instantiated twice, for TX and RX.
- The top level contains the TX FSM and serialiser, the RX assembler and the error logic.

Test Plan:
- Defaults. Write 32'h13A5B6C7 with free_outbound=1 -> put_outbound high 4 consecutive cycles with payload 13, A5, B6, C7, starting the cycle after the edge following the write.
- Write 5 packets back-to-back with free_outbound=0 -> cQ_full=1 after the 4th, 5th dropped, tx_count=4. Then raise free_outbound -> 4 packets sent in order, 1 idle cycle between each.
- Inbound flits 2B, (2 idle), 01, 02, (1 idle), 03 with pkt_out_ready=0 -> pkt_out=32'h2B010203, pkt_out_avail=1, rx_count=1.
- With RXQ_DEPTH=2 and pkt_out_ready=0, deliver 2 packets -> free_inbound=0 from the first flit of packet 2. An extra put_inbound afterwards -> rx_err=1, rx_count stays 2.
- Assert reset mid-SEND (after flit 2) and mid-assembly -> put_outbound=0 immediately, queues empty, free_inbound=1. A subsequent clean packet transfers correctly.
- PKT_W=48, FLIT_W=16, TXQ_DEPTH=3: write 48'h0102_0304_0506 -> flits 0102, 0304, 0506. Looped back into the inbound port -> pkt_out=48'h010203040506.
